// File: rtl/bp_upd_pkg.sv
// Shared types and defaults for the branch-predictor update arbiter.
//   XLEN            : address width of branch/target PCs
//   NUM_REQ_DEF     : default number of branch resolution ports
//   DEPTH_DEF       : default update FIFO depth
//   bp_upd_entry_t  : one queued predictor update
package bp_upd_pkg;
  localparam int XLEN        = 32;
  localparam int NUM_REQ_DEF = 2;
  localparam int DEPTH_DEF   = 4;

  typedef struct packed {
    logic            direction;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] branch_PC;
  } bp_upd_entry_t;
endpackage

// File: rtl/bp_upd_fifo.sv
// Multi-push / single-pop circular buffer of predictor updates.
//   clock, reset : rising-edge clock, async active-low reset
//   wr_data      : compacted entries, slot k written at wptr+k
//   wr_num       : number of valid entries in wr_data (0..NUM_REQ)
//   pop          : advance head by one (caller guarantees non-empty)
//   head         : entry at read pointer (undefined when empty)
//   count, free  : occupancy and free slots
module bp_upd_fifo
  import bp_upd_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  bp_upd_entry_t [NUM_REQ-1:0]   wr_data,
  input  logic [CW-1:0]                 wr_num,
  input  logic                          pop,
  output bp_upd_entry_t                 head,
  output logic [CW-1:0]                 count,
  output logic [CW-1:0]                 free
);

  logic [AW-1:0]              wptr, rptr;
  logic [NUM_REQ-1:0][AW-1:0] widx;
  bp_upd_entry_t              mem [DEPTH];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_widx
    assign widx[k] = wptr + AW'(k);
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_REQ; k++)
      if (CW'(k) < wr_num) mem[widx[k]] <= wr_data[k];
  end

  // wr_num <= DEPTH, so its low AW bits advance the pointer modulo DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + wr_num[AW-1:0];
      rptr  <= rptr + AW'(pop);
      count <= count + wr_num - CW'(pop);
    end
  end

  assign head = mem[rptr];
  assign free = CW'(DEPTH) - count;

endmodule

// File: rtl/bp_update_arbiter.sv
// Funnels resolved branches from NUM_REQ ports into the predictor's single
// update port, one per cycle, in port-priority order through a small FIFO.
//   clock, reset      : rising-edge clock, async active-low reset
//   req_valid/_direction/_PC/_branch_PC : per-port resolution
//   req_ready         : port i may present (free slots > i)
//   pred_busy         : predictor refuses the head this cycle
//   result_*          : head update, zeros when empty
//   prev_branch_PC    : branch PC of the head update
//   upd_count         : FIFO occupancy
// Optional: define BP_UPD_BYPASS_EN to forward the lowest accepted request
// straight to the outputs when the FIFO is empty and the predictor is free.
module bp_update_arbiter
  import bp_upd_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_direction,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_PC,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_branch_PC,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          pred_busy,
  output logic                          result_enable,
  output logic                          result_direction,
  output logic [XLEN-1:0]               result_PC,
  output logic [XLEN-1:0]               prev_branch_PC,
  output logic [CW-1:0]                 upd_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  bp_upd_entry_t [NUM_REQ-1:0] req_ent, wr_data;
  bp_upd_entry_t               head, res;
  logic [NUM_REQ-1:0]          acc, push_mask;
  logic [CW-1:0]               count, free, wr_num;
  logic [IW-1:0]               slot;
  logic                        not_empty, pop;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
    assign req_ent[i]   = '{direction: req_direction[i],
                            target:    req_PC[i],
                            branch_PC: req_branch_PC[i]};
    assign req_ready[i] = free > CW'(i);
  end

  assign acc       = req_valid & req_ready;
  assign not_empty = (count != '0);
  assign pop       = not_empty & ~pred_busy;

`ifdef BP_UPD_BYPASS_EN
  logic [NUM_REQ-1:0] low;
  logic               byp_act;
  bp_upd_entry_t      byp_ent;

  assign low       = acc & (~acc + NUM_REQ'(1));   // lowest accepted port
  assign byp_act   = ~not_empty & ~pred_busy & (|acc);
  assign push_mask = byp_act ? (acc & ~low) : acc;

  always_comb begin
    byp_ent = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (acc[i]) byp_ent = req_ent[i];
  end
`else
  assign push_mask = acc;
`endif

  // Pack surviving requests into consecutive slots, lowest port first.
  always_comb begin
    wr_data = '0;
    wr_num  = '0;
    slot    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push_mask[i]) begin
        wr_data[slot] = req_ent[i];
        wr_num        = wr_num + CW'(1);
        slot          = slot + IW'(1);
      end
    end
  end

  bp_upd_fifo #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_num  (wr_num),
    .pop     (pop),
    .head    (head),
    .count   (count),
    .free    (free)
  );

  always_comb begin
    res           = '0;
    result_enable = 1'b0;
    if (not_empty) begin
      res           = head;
      result_enable = 1'b1;
    end
`ifdef BP_UPD_BYPASS_EN
    else if (byp_act) begin
      res           = byp_ent;
      result_enable = 1'b1;
    end
`endif
  end

  assign result_direction = res.direction;
  assign result_PC        = res.target;
  assign prev_branch_PC   = res.branch_PC;
  assign upd_count        = count;

endmodule

// File: tb/tb_bp_update_arbiter.sv
module tb_bp_update_arbiter;
  import bp_upd_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid, req_direction, req_ready;
  logic [1:0][XLEN-1:0] req_PC, req_branch_PC;
  logic                 pred_busy;
  logic                 result_enable, result_direction;
  logic [XLEN-1:0]      result_PC, prev_branch_PC;
  logic [2:0]           upd_count;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  bp_update_arbiter #(.NUM_REQ(2), .DEPTH(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_direction    (req_direction),
    .req_PC           (req_PC),
    .req_branch_PC    (req_branch_PC),
    .req_ready        (req_ready),
    .pred_busy        (pred_busy),
    .result_enable    (result_enable),
    .result_direction (result_direction),
    .result_PC        (result_PC),
    .prev_branch_PC   (prev_branch_PC),
    .upd_count        (upd_count)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] d,
                       input logic [XLEN-1:0] p0, input logic [XLEN-1:0] b0,
                       input logic [XLEN-1:0] p1, input logic [XLEN-1:0] b1);
    req_valid        = v;
    req_direction    = d;
    req_PC[0]        = p0;
    req_branch_PC[0] = b0;
    req_PC[1]        = p1;
    req_branch_PC[1] = b1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    pred_busy = 1'b0;
    idle();
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if ({result_enable, upd_count} !== 4'b0_000) begin
      fails++; $display("FAIL reset_hold: en/count got %b/%0d exp 0/0", result_enable, upd_count);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({result_enable, upd_count, req_ready} !== 6'b0_000_11) begin
      fails++; $display("FAIL reset_state: en/count/ready got %b/%0d/%b exp 0/0/11", result_enable, upd_count, req_ready);
    end
    tests++;
    if ({result_PC, prev_branch_PC, result_direction} !== {65{1'b0}}) begin
      fails++; $display("FAIL reset_data: pc %h bpc %h dir %b exp zeros", result_PC, prev_branch_PC, result_direction);
    end
  endtask

  task automatic test_single();
    cyc();
    pred_busy = 1'b0;
    drive(2'b01, 2'b01, 32'h100, 32'hF0, '0, '0);
    #1;
    tests++;
    if (req_ready !== 2'b11) begin
      fails++; $display("FAIL single_ready: got %b exp 11", req_ready);
    end
`ifdef BP_UPD_BYPASS_EN
    tests++;
    if ({result_enable, result_direction, result_PC, prev_branch_PC} !== {1'b1, 1'b1, 32'h100, 32'hF0}) begin
      fails++; $display("FAIL single_bypass: en %b dir %b pc %h bpc %h exp 1 1 100 f0", result_enable, result_direction, result_PC, prev_branch_PC);
    end
    cyc();
    idle();
    #1;
    tests++;
    if ({result_enable, upd_count} !== 4'b0_000) begin
      fails++; $display("FAIL single_after: en/count got %b/%0d exp 0/0", result_enable, upd_count);
    end
`else
    tests++;
    if (result_enable !== 1'b0) begin
      fails++; $display("FAIL single_lat: en got %b exp 0 in accept cycle", result_enable);
    end
    cyc();
    idle();
    #1;
    tests++;
    if ({result_enable, result_direction, result_PC, prev_branch_PC, upd_count} !== {1'b1, 1'b1, 32'h100, 32'hF0, 3'd1}) begin
      fails++; $display("FAIL single_out: en %b dir %b pc %h bpc %h cnt %0d exp 1 1 100 f0 1", result_enable, result_direction, result_PC, prev_branch_PC, upd_count);
    end
    cyc();
    #1;
    tests++;
    if ({result_enable, upd_count, result_PC} !== {1'b0, 3'd0, 32'h0}) begin
      fails++; $display("FAIL single_drain: en %b cnt %0d pc %h exp 0 0 0", result_enable, upd_count, result_PC);
    end
`endif
  endtask

  task automatic test_dual();
    cyc();
    drive(2'b11, 2'b01, 32'h10, 32'h11, 32'h20, 32'h21);
`ifdef BP_UPD_BYPASS_EN
    #1;
    tests++;
    if ({result_enable, result_PC} !== {1'b1, 32'h10}) begin
      fails++; $display("FAIL dual_first: en %b pc %h exp 1 10", result_enable, result_PC);
    end
    cyc();
    idle();
    #1;
`else
    cyc();
    idle();
    #1;
    tests++;
    if ({result_enable, result_direction, result_PC, prev_branch_PC, upd_count} !== {1'b1, 1'b1, 32'h10, 32'h11, 3'd2}) begin
      fails++; $display("FAIL dual_first: en %b dir %b pc %h bpc %h cnt %0d exp 1 1 10 11 2", result_enable, result_direction, result_PC, prev_branch_PC, upd_count);
    end
    cyc();
    #1;
`endif
    tests++;
    if ({result_enable, result_direction, result_PC, prev_branch_PC, upd_count} !== {1'b1, 1'b0, 32'h20, 32'h21, 3'd1}) begin
      fails++; $display("FAIL dual_second: en %b dir %b pc %h bpc %h cnt %0d exp 1 0 20 21 1", result_enable, result_direction, result_PC, prev_branch_PC, upd_count);
    end
    cyc();
    #1;
    tests++;
    if ({result_enable, upd_count} !== 4'b0_000) begin
      fails++; $display("FAIL dual_drain: en/count got %b/%0d exp 0/0", result_enable, upd_count);
    end
  endtask

  task automatic test_fill();
    cyc();
    pred_busy = 1'b1;
    drive(2'b11, 2'b11, 32'hA1, 32'hB1, 32'hA2, 32'hB2);
    cyc();
    drive(2'b11, 2'b00, 32'hA3, 32'hB3, 32'hA4, 32'hB4);
    #1;
    tests++;
    if ({upd_count, req_ready, result_enable, result_PC} !== {3'd2, 2'b11, 1'b1, 32'hA1}) begin
      fails++; $display("FAIL fill_half: cnt %0d rdy %b en %b pc %h exp 2 11 1 a1", upd_count, req_ready, result_enable, result_PC);
    end
    cyc();
    idle();
    #1;
    tests++;
    if ({upd_count, req_ready, result_enable, result_PC} !== {3'd4, 2'b00, 1'b1, 32'hA1}) begin
      fails++; $display("FAIL fill_full: cnt %0d rdy %b en %b pc %h exp 4 00 1 a1", upd_count, req_ready, result_enable, result_PC);
    end
    cyc();
    #1;
    tests++;
    if ({upd_count, result_enable, result_PC, prev_branch_PC} !== {3'd4, 1'b1, 32'hA1, 32'hB1}) begin
      fails++; $display("FAIL fill_hold: cnt %0d en %b pc %h bpc %h exp 4 1 a1 b1", upd_count, result_enable, result_PC, prev_branch_PC);
    end
    pred_busy = 1'b0;
    cyc();
    #1;
    tests++;
    if ({upd_count, req_ready, result_PC} !== {3'd3, 2'b01, 32'hA2}) begin
      fails++; $display("FAIL fill_pop1: cnt %0d rdy %b pc %h exp 3 01 a2", upd_count, req_ready, result_PC);
    end
    cyc();
    #1;
    tests++;
    if ({upd_count, req_ready, result_PC} !== {3'd2, 2'b11, 32'hA3}) begin
      fails++; $display("FAIL fill_pop2: cnt %0d rdy %b pc %h exp 2 11 a3", upd_count, req_ready, result_PC);
    end
    cyc();
    #1;
    tests++;
    if ({upd_count, result_enable, result_PC, prev_branch_PC} !== {3'd1, 1'b1, 32'hA4, 32'hB4}) begin
      fails++; $display("FAIL fill_pop3: cnt %0d en %b pc %h bpc %h exp 1 1 a4 b4", upd_count, result_enable, result_PC, prev_branch_PC);
    end
    cyc();
    #1;
    tests++;
    if ({upd_count, result_enable} !== 4'b000_0) begin
      fails++; $display("FAIL fill_empty: cnt %0d en %b exp 0 0", upd_count, result_enable);
    end
  endtask

  // Single-port stream with a queue scoreboard; port-1 requests made while
  // free < 2 must be dropped. The table never offers a request to an empty
  // FIFO with the predictor free, so the same expectations hold with bypass.
  task automatic test_wrap();
    logic [1:0]      wv [16] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00,
                                 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
    logic            wb [16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [XLEN-1:0] q [$];
    logic [XLEN-1:0] pc, hd;
    logic [1:0]      exp_rdy;
    int              size;
    int              pushed = 0;
    for (int c = 0; c < 16; c++) begin
      cyc();
      pc        = 32'h200 + c;
      pred_busy = wb[c];
      drive(wv[c], {2{pc[0]}}, pc, pc + 32'h100, pc, pc + 32'h100);
      #1;
      size    = q.size();
      exp_rdy = {(4 - size) > 1, (4 - size) > 0};
      tests++;
      if ({upd_count, req_ready} !== {3'(size), exp_rdy}) begin
        fails++; $display("FAIL wrap_state c%0d: cnt %0d rdy %b exp %0d %b", c, upd_count, req_ready, size, exp_rdy);
      end
      if (size > 0) begin
        hd = q[0];
        tests++;
        if ({result_enable, result_direction, result_PC, prev_branch_PC} !== {1'b1, hd[0], hd, hd + 32'h100}) begin
          fails++; $display("FAIL wrap_head c%0d: en %b dir %b pc %h bpc %h exp head %h", c, result_enable, result_direction, result_PC, prev_branch_PC, hd);
        end
      end
      if (!wb[c] && size > 0) void'(q.pop_front());
      for (int i = 0; i < 2; i++)
        if (wv[c][i] && (4 - size) > i) begin
          q.push_back(pc);
          pushed++;
        end
    end
    idle();
    cyc();
    tests++;
    if ({result_enable, upd_count, 8'(pushed)} !== {1'b0, 3'd0, 8'd10}) begin
      fails++; $display("FAIL wrap_end: en %b cnt %0d pushed %0d exp 0 0 10", result_enable, upd_count, pushed);
    end
  endtask

  task automatic test_mid_reset();
    pred_busy = 1'b1;
    drive(2'b11, 2'b00, 32'hD1, 32'hE1, 32'hD2, 32'hE2);
    cyc();
    drive(2'b01, 2'b00, 32'hD3, 32'hE3, '0, '0);
    cyc();
    idle();
    #1;
    tests++;
    if ({upd_count, result_PC} !== {3'd3, 32'hD1}) begin
      fails++; $display("FAIL midrst_pre: cnt %0d pc %h exp 3 d1", upd_count, result_PC);
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({result_enable, upd_count, result_PC, req_ready} !== {1'b0, 3'd0, 32'h0, 2'b11}) begin
      fails++; $display("FAIL midrst_async: en %b cnt %0d pc %h rdy %b exp 0 0 0 11", result_enable, upd_count, result_PC, req_ready);
    end
    cyc();
    reset     = 1'b1;
    pred_busy = 1'b0;
    #1;
    tests++;
    if ({result_enable, upd_count} !== 4'b0_000) begin
      fails++; $display("FAIL midrst_stale: en %b cnt %0d exp 0 0", result_enable, upd_count);
    end
    cyc();
    drive(2'b01, 2'b01, 32'hC1, 32'hC2, '0, '0);
`ifdef BP_UPD_BYPASS_EN
    #1;
    tests++;
    if ({result_enable, result_PC, prev_branch_PC} !== {1'b1, 32'hC1, 32'hC2}) begin
      fails++; $display("FAIL midrst_new: en %b pc %h bpc %h exp 1 c1 c2", result_enable, result_PC, prev_branch_PC);
    end
    cyc();
    idle();
    #1;
`else
    cyc();
    idle();
    #1;
    tests++;
    if ({result_enable, result_PC, prev_branch_PC, upd_count} !== {1'b1, 32'hC1, 32'hC2, 3'd1}) begin
      fails++; $display("FAIL midrst_new: en %b pc %h bpc %h cnt %0d exp 1 c1 c2 1", result_enable, result_PC, prev_branch_PC, upd_count);
    end
    cyc();
    #1;
`endif
    tests++;
    if ({result_enable, upd_count} !== 4'b0_000) begin
      fails++; $display("FAIL midrst_drain: en %b cnt %0d exp 0 0", result_enable, upd_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_fill();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_update_arbiter.md
# bp_update_arbiter

Collects resolved-branch outcomes from up to `NUM_REQ` branch execution ports and delivers them one per cycle to the branch predictor's update port (`result_enable`, `result_direction`, `result_PC`, `prev_branch_PC`). It sits between the branch functional units and `predictor`. Updates are buffered in a small in-order FIFO so that simultaneous resolutions are never lost and arrive at the predictor in port-priority order. The FIFO also absorbs cycles in which the predictor refuses updates.

## Interface
- `NUM_REQ`, default 2: number of branch resolution ports; port 0 is oldest and has highest priority.
- `DEPTH`, default 4: FIFO entries; power of two, must be ≥ `NUM_REQ`.
- `clock` in 1: system clock, all state on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: resolution valid, per port.
- `req_direction` in `NUM_REQ`: actual taken/not-taken, per port.
- `req_PC` in `NUM_REQ`×`XLEN`: resolved target address, per port.
- `req_branch_PC` in `NUM_REQ`×`XLEN`: PC of the branch itself, per port.
- `req_ready` out `NUM_REQ`: port i may present an update this cycle.
- `pred_busy` in 1: the predictor cannot accept an update this cycle.
- `result_enable` out 1: update valid to the predictor.
- `result_direction` out 1: actual direction of the head update.
- `result_PC` out `XLEN`: target address of the head update.
- `prev_branch_PC` out `XLEN`: branch PC of the head update.
- `upd_count` out clog2(`DEPTH`)+1: current FIFO occupancy.

## Operation
- `req_ready[i]` = (free slots > i). The signal is combinational from registered occupancy and is independent of `req_valid`.
- Accepted set: ports with `req_valid[i] & req_ready[i]`. An upstream unit must not assert `req_valid` without `req_ready`; if it does, the request is ignored and is not stored.
- Accepted requests are written in ascending port order into consecutive slots at the write pointer. A gap is allowed: for example, port 1 alone takes the next slot.
- Output: when the FIFO is non-empty, `result_enable`=1 and the other result outputs show the head entry.
- Pop: happens when `result_enable & ~pred_busy`. The head advances by one.
- When `pred_busy`=1, the outputs hold the same head entry with `result_enable` still high. The predictor ignores it.
- Empty: `result_enable`=0 and the data outputs are 0.
- Pointers: `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`. Occupancy is tracked in a separate counter, so full and empty are unambiguous.
- Occupancy update each cycle: `upd_count` ← `upd_count` + pushes − pop. Simultaneous push and pop on a full FIFO is impossible because `req_ready` is computed from registered occupancy. Simultaneous push and pop on any other state is legal.
- Reset at any time, including mid-drain, clears both pointers and the count and discards all entries.
- Reset values: `result_enable`=0, data outputs=0, `upd_count`=0, `req_ready`=all 1.

## Timing
- Without bypass: a request accepted in cycle N is visible on the result outputs at cycle N+1 at the earliest, and is popped at the end of the first cycle ≥N+1 in which `pred_busy`=0 and it is at the head.
- Throughput: one update per cycle to the predictor. Up to `NUM_REQ` updates are accepted per cycle.
- All outputs are combinational from registers only, unless bypass is enabled.

## Configuration
- `BP_UPD_BYPASS_EN` defined:
  - Applies when the FIFO is empty and `pred_busy`=0.
  - The lowest-index accepted request drives the result outputs combinationally in the same cycle and is not stored.
  - Remaining accepted requests are enqueued.
  - Latency becomes 0 cycles.
- `BP_UPD_BYPASS_EN` undefined: every update passes through the FIFO, giving a minimum latency of 1 cycle, and the outputs are purely registered.

## Structure
- Package `bp_upd_pkg`:
  - `bp_upd_entry_t` struct: `direction`, `target` [`XLEN`], `branch_PC` [`XLEN`].
  - Default constants for `NUM_REQ` and `DEPTH`.
- Sub-module `bp_upd_fifo`:
  - Multi-push (up to `NUM_REQ`), single-pop circular buffer of `bp_upd_entry_t`.
  - Exports head, count and free count.
- Top level: ready generation, push compaction, and the bypass mux.

## Test plan
- Reset with `reset`=0, release, then check `result_enable`=0, `upd_count`=0, `req_ready`=2'b11.
- Single update: port 0 sends taken, target 0x100, branch PC 0xF0, with `pred_busy`=0. Outputs appear next cycle (same cycle with bypass) and `upd_count` returns to 0.
- Dual update: ports 0 and 1 are valid together (PCs 0x10 and 0x20). The predictor sees 0x10 then 0x20 on consecutive cycles.
- Stall and fill: hold `pred_busy`=1 and push 2+2 entries.
  - `upd_count`=4 and `req_ready`=2'b00.
  - Release `pred_busy`: four pops in order, and `req_ready[1]` rises once free ≥ 2.
- Wrap-around: stream 10 single updates with occupancy oscillating. Order is preserved across pointer wrap, and only port 1 valid occupies the next slot.
- Mid-operation reset: assert `reset`=0 with 3 entries queued. The next update after release is the first new request; no stale entry is ever output.
